// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default parameters for the instruction-fetch
// sequencer (fetch_ctrl and its interface).
package fetch_pkg;

   // Sequencer states; the encoding is fixed here so every user agrees on it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   localparam int unsigned FETCH_PC_W       = 32'd12;
   localparam int unsigned FETCH_OFF_W      = 32'd8;
   localparam int unsigned FETCH_START_ADDR = 32'd0;

endpackage : fetch_pkg

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: harness/decoder <-> fetch sequencer signal bundle.
// master = harness + decoder side, slave = fetch_ctrl.
interface fetch_ctrl_if
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W  = FETCH_PC_W,
   parameter int unsigned OFF_W = FETCH_OFF_W
);
   logic              Start;
   logic              Stall;
   logic              BranchEn;
   logic              BranchAbs;
   logic [PC_W-1:0]   BranchTarget;
   logic [OFF_W-1:0]  BranchOff;
   logic              Halt;
   logic [PC_W-1:0]   InstAddress;
   logic              FetchValid;
   logic              Done;
   logic              Overrun;

   modport master (
      output Start, Stall, BranchEn, BranchAbs, BranchTarget, BranchOff, Halt,
      input  InstAddress, FetchValid, Done, Overrun
   );

   modport slave (
      input  Start, Stall, BranchEn, BranchAbs, BranchTarget, BranchOff, Halt,
      output InstAddress, FetchValid, Done, Overrun
   );
endinterface : fetch_ctrl_if

// File: rtl/fetch_cycle_ctr.sv
// fetch_cycle_ctr: 16-bit saturating counter of clock edges spent in RUN.
// Only instantiated when FETCH_CYCLE_CNT_EN is defined.
module fetch_cycle_ctr (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        en_i,
   output logic [15:0] count_o
);
   logic [15:0] count_q;
   logic [15:0] count_d;

   // Next count: clear wins, otherwise increment until saturated at 0xFFFF.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = 16'd0;
      end else if (en_i && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Counter register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule : fetch_cycle_ctr

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer for the combinational instruction ROM.
// Runs from Start to a Halt instruction, honouring stall, absolute/relative
// branches and PC wrap (sticky Overrun).
// Optional feature macro: FETCH_CYCLE_CNT_EN adds a 16-bit CycleCount output.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned PC_W       = FETCH_PC_W,
   parameter int unsigned OFF_W      = FETCH_OFF_W,
   parameter int unsigned START_ADDR = FETCH_START_ADDR
) (
   input  logic        Clk,
   input  logic        Reset,
   fetch_ctrl_if.slave bus
`ifdef FETCH_CYCLE_CNT_EN
   ,
   output logic [15:0] CycleCount
`endif
);
   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0] PC_MAX   = {PC_W{1'b1}};

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              overrun_q, overrun_d;
   logic [PC_W-1:0]   off_ext_s;
   logic              fetch_valid_s;
   logic              done_s;

   // Relative offsets are two's complement; widen to PC width before adding.
   assign off_ext_s = {{(PC_W-OFF_W){bus.BranchOff[OFF_W-1]}}, bus.BranchOff};

   // State, PC and Overrun registers; reset is asynchronous, release is clocked.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         pc_q      <= START_PC;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         overrun_q <= overrun_d;
      end
   end

   // Next state and next PC: stall > halt > absolute > relative > increment.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      overrun_d = overrun_q;
      case (state_q)
         IDLE, HALT: begin
            if (bus.Start) begin
               state_d   = RUN;
               pc_d      = START_PC;
               overrun_d = 1'b0;
            end else begin
               state_d   = state_q;
            end
         end
         RUN: begin
            if (bus.Stall) begin
               pc_d = pc_q;
            end else if (bus.Halt) begin
               state_d = HALT;
            end else if (bus.BranchEn && bus.BranchAbs) begin
               pc_d = bus.BranchTarget;
            end else if (bus.BranchEn) begin
               // A relative branch across zero is intentional and not an overrun.
               pc_d = pc_q + off_ext_s;
            end else begin
               pc_d = pc_q + PC_W'(1'b1);
               if (pc_q == PC_MAX) begin
                  overrun_d = 1'b1;
               end else begin
                  overrun_d = overrun_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_PC;
         end
      endcase
   end

   // Status outputs decode the registered state only, never the inputs.
   always_comb begin
      fetch_valid_s = 1'b0;
      done_s        = 1'b0;
      case (state_q)
         RUN:     fetch_valid_s = 1'b1;
         HALT:    done_s        = 1'b1;
         default: begin
            fetch_valid_s = 1'b0;
            done_s        = 1'b0;
         end
      endcase
   end

   assign bus.InstAddress = pc_q;
   assign bus.FetchValid  = fetch_valid_s;
   assign bus.Done        = done_s;
   assign bus.Overrun     = overrun_q;

`ifdef FETCH_CYCLE_CNT_EN
   logic start_accept_s;
   logic in_run_s;

   assign start_accept_s = bus.Start && ((state_q == IDLE) || (state_q == HALT));
   assign in_run_s       = (state_q == RUN);

   fetch_cycle_ctr u_cycle_ctr (
      .clk     (Clk),
      .rst_n   (Reset),
      .clr_i   (start_accept_s),
      .en_i    (in_run_s),
      .count_o (CycleCount)
   );
`endif
endmodule : fetch_ctrl
